// File: rtl/multi_button_shaper.sv
// N-channel button debouncer: 2-flop synchronizer, debounce FSM, one-cycle press pulse and held level.
// Optional auto-repeat while held is built when BTN_SHAPER_REPEAT_EN is defined.
module multi_button_shaper #(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [N_BUTTONS-1:0] B_in,
  output logic [N_BUTTONS-1:0] B_out,
  output logic [N_BUTTONS-1:0] B_held,
  output logic                 B_any
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [N_BUTTONS-1:0] RELEASED = (ACTIVE_LOW != 0) ? {N_BUTTONS{1'b1}} : {N_BUTTONS{1'b0}};

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("multi_button_shaper: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    PULSE    = 3'd2,
    HELD     = 3'd3,
    DB_REL   = 3'd4
  } state_t;

  state_t               state_q [N_BUTTONS];
  state_t               state_d [N_BUTTONS];
  logic [CW-1:0]        cnt_q   [N_BUTTONS];
  logic [CW-1:0]        cnt_d   [N_BUTTONS];
  logic [N_BUTTONS-1:0] sync1_q, sync2_q;
  logic [N_BUTTONS-1:0] out_q, out_d;
  logic [N_BUTTONS-1:0] held_q, held_d;
  logic [N_BUTTONS-1:0] p_s;

`ifdef BTN_SHAPER_REPEAT_EN
  // rpt_q holds the number of HELD cycles left until the next repeat pulse.
  localparam logic [15:0] RPT_FIRST = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] RPT_NEXT  = 16'(REPEAT_PERIOD - 1);
  logic [15:0]          rpt_q [N_BUTTONS];
  logic [15:0]          rpt_d [N_BUTTONS];
  logic [N_BUTTONS-1:0] rpt_fire_s;
`endif

  always_comb begin
    p_s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  end

  always_comb begin
    out_d  = {N_BUTTONS{1'b0}};
    held_d = {N_BUTTONS{1'b0}};
`ifdef BTN_SHAPER_REPEAT_EN
    rpt_fire_s = {N_BUTTONS{1'b0}};
`endif
    for (int i = 0; i < N_BUTTONS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (p_s[i]) begin
            state_d[i] = DB_PRESS;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = CNT_ZERO;
          end
        end
        DB_PRESS: begin
          if (!p_s[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = CNT_ZERO;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = PULSE;
            cnt_d[i]   = CNT_ZERO;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        PULSE: begin
          state_d[i] = HELD;
          cnt_d[i]   = CNT_ZERO;
        end
        HELD: begin
          if (!p_s[i]) begin
            state_d[i] = DB_REL;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = CNT_ZERO;
          end
        end
        DB_REL: begin
          if (p_s[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = CNT_ZERO;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = IDLE;
            cnt_d[i]   = CNT_ZERO;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = CNT_ZERO;
        end
      endcase

`ifdef BTN_SHAPER_REPEAT_EN
      rpt_d[i] = rpt_q[i];
      if (state_d[i] == IDLE) begin
        rpt_d[i] = 16'd0;
      end else if (state_d[i] == HELD) begin
        if (state_q[i] == PULSE) begin
          rpt_d[i] = RPT_FIRST;
        end else if (rpt_q[i] == 16'd0) begin
          rpt_d[i] = RPT_NEXT;
        end else begin
          rpt_d[i] = rpt_q[i] - 16'd1;
        end
        rpt_fire_s[i] = (rpt_d[i] == 16'd0);
      end else begin
        rpt_d[i] = rpt_q[i];
      end
      out_d[i] = (state_d[i] == PULSE) || rpt_fire_s[i];
`else
      out_d[i] = (state_d[i] == PULSE);
`endif
      held_d[i] = (state_d[i] == PULSE) || (state_d[i] == HELD) || (state_d[i] == DB_REL);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
      out_q   <= {N_BUTTONS{1'b0}};
      held_q  <= {N_BUTTONS{1'b0}};
      for (int i = 0; i < N_BUTTONS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= CNT_ZERO;
`ifdef BTN_SHAPER_REPEAT_EN
        rpt_q[i]   <= 16'd0;
`endif
      end
    end else begin
      sync1_q <= B_in;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      held_q  <= held_d;
      for (int i = 0; i < N_BUTTONS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef BTN_SHAPER_REPEAT_EN
        rpt_q[i]   <= rpt_d[i];
`endif
      end
    end
  end

  assign B_out  = out_q;
  assign B_held = held_q;
  assign B_any  = |out_q;

endmodule
